spi_rx_ip_top: RTL and testbench

SPI_RX_IP_TOP -- requirements
Module: spi_rx_ip_top

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync.sv | 28 ++
 rtl/spi_rx_ip_top.sv | 169 ++++++++++++++++
 tb/tb_spi_rx_ip_top.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions: state encoding, data width, control/status bit positions
package spi_pkg;

  localparam int DATA_W = 8;

  // control register bit positions
  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_CLR_STATUS = 1;

  // status register bit positions
  localparam int STAT_OVERRUN    = 0;
  localparam int STAT_FRAME_ERR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - single-bit multi-flop synchronizer with configurable depth and reset value
module spi_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  // shift the asynchronous input through DEPTH flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_rx_ip_top.sv
// rtl/spi_rx_ip_top.sv - SPI mode-0 receiver with data/command tag, valid/ready output and sticky status
module spi_rx_ip_top
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        control,
  input  logic              cs_in,
  input  logic              scl_in,
  input  logic              sda_in,
  input  logic              dc_in,
  output logic [DATA_W-1:0] data_out,
  output logic              dc_out,
  output logic              valid,
  input  logic              ready,
  output logic [1:0]        status
);

  localparam int CNT_W   = $clog2(DATA_W);
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic cs_s, scl_s, sda_s, dc_s;
  logic cs_prev_q, scl_prev_q;
  logic [FLUSH_W-1:0] flush_q;
  logic flushed, cs_fall, cs_rise, scl_rise;
  logic enable, clr_status;

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              byte_done_q, byte_done_d;
  logic              dc_cap_q, dc_cap_d;
  logic              frame_err_set, overrun_set;

  logic [DATA_W-1:0] data_q, data_d;
  logic              dc_q, dc_d, valid_q, valid_d;
  logic              overrun_q, overrun_d, frame_err_q, frame_err_d;

  assign enable     = control[CTRL_ENABLE];
  assign clr_status = control[CTRL_CLR_STATUS];

  // cs idles high, so its synchronizer presets to 1 to avoid a phantom fall at reset
  spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .reset(reset), .d_i(cs_in),  .q_o(cs_s));
  spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (.clk(clk), .reset(reset), .d_i(scl_in), .q_o(scl_s));
  spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sda (.clk(clk), .reset(reset), .d_i(sda_in), .q_o(sda_s));
  spi_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dc  (.clk(clk), .reset(reset), .d_i(dc_in),  .q_o(dc_s));

  assign flushed  = (flush_q == FLUSH_W'(SYNC_STAGES));
  assign scl_rise = scl_s & ~scl_prev_q;
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;

  // edge history; cs history stays low until the synchronizers hold real samples,
  // so a cs already low when reset releases never looks like a fresh frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_q    <= '0;
      scl_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      if (!flushed) flush_q <= flush_q + FLUSH_W'(1);
      scl_prev_q <= scl_s;
      cs_prev_q  <= flushed & cs_s;
    end
  end

  // receiver state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      dc_cap_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      dc_cap_q    <= dc_cap_d;
    end
  end

  // next-state: frame start on cs fall, shift on scl rise, frame end on cs rise
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    byte_done_d   = 1'b0;
    dc_cap_d      = dc_cap_q;
    frame_err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d       = ST_END;
          frame_err_set = (cnt_q != '0);
        end else if (scl_rise) begin
          shift_d = {shift_q[DATA_W-2:0], sda_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            byte_done_d = 1'b1;
            dc_cap_d    = dc_s;
          end
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d       = ST_IDLE;
      byte_done_d   = 1'b0;
      frame_err_set = 1'b0;
    end
  end

  // output holding register and sticky flags; a set event beats a clear
  always_comb begin
    data_d      = data_q;
    dc_d        = dc_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;
    if (byte_done_q) begin
      if (valid_q && !ready) begin
        overrun_set = 1'b1;
      end else begin
        data_d  = shift_q;
        dc_d    = dc_cap_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    overrun_d   = (overrun_q & ~clr_status) | overrun_set;
    frame_err_d = (frame_err_q & ~clr_status) | frame_err_set;
  end

  // output register update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      dc_q        <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      dc_q        <= dc_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out                = data_q;
  assign dc_out                  = dc_q;
  assign valid                   = valid_q;
  assign status[STAT_OVERRUN]    = overrun_q;
  assign status[STAT_FRAME_ERR]  = frame_err_q;

endmodule

// File: tb/tb_spi_rx_ip_top.sv
// tb/tb_spi_rx_ip_top.sv - scoreboard bench for spi_rx_ip_top
module tb_spi_rx_ip_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] control;
  logic       cs_in, scl_in, sda_in, dc_in;
  logic [7:0] data_out;
  logic       dc_out, valid, ready;
  logic [1:0] status;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  spi_rx_ip_top #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .control(control),
    .cs_in(cs_in), .scl_in(scl_in), .sda_in(sda_in), .dc_in(dc_in),
    .data_out(data_out), .dc_out(dc_out), .valid(valid), .ready(ready),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // every accepted byte must match the oldest expected entry
  always @(negedge clk) begin
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check_eq("data_out", 32'(data_out), 32'(e[7:0]));
        check_eq("dc_out", 32'(dc_out), 32'(e[8]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drives n bits MSB first; returns just after the last rising scl is driven
  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      sda_in = d[7-i];
      scl_in = 1'b0;
      tick(5);
      scl_in = 1'b1;
      if (i != n - 1) tick(5);
    end
  endtask

  task automatic cs_low();
    cs_in = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    scl_in = 1'b0;
    tick(5);
    cs_in = 1'b1;
    tick(6);
  endtask

  task automatic clr_pulse();
    control = 2'b11;
    tick(1);
    control = 2'b01;
    tick(1);
  endtask

  initial begin
    reset = 1'b0; control = 2'b00; ready = 1'b0;
    cs_in = 1'b1; scl_in = 1'b0; sda_in = 1'b0; dc_in = 1'b0;
    tick(3);
    check_eq("rst_data", 32'(data_out), 32'h00);
    check_eq("rst_dc", 32'(dc_out), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_status", 32'(status), 32'd0);
    reset = 1'b1;
    control = 2'b01;
    tick(5);

    // single byte, latency and one-cycle valid pulse
    ready = 1'b1; dc_in = 1'b1;
    cs_low();
    exp_q.push_back({1'b1, 8'hA5});
    send_bits(8'hA5, 8);
    tick(3);
    check_eq("lat_e2_valid", 32'(valid), 32'd0);
    tick(1);
    check_eq("lat_e3_valid", 32'(valid), 32'd1);
    tick(1);
    check_eq("pulse_valid", 32'(valid), 32'd0);
    cs_high();
    check_eq("t1_status", 32'(status), 32'd0);

    // overrun: second byte discarded
    ready = 1'b0; dc_in = 1'b0;
    cs_low();
    exp_q.push_back({1'b0, 8'h3C});
    send_bits(8'h3C, 8);
    tick(5);
    send_bits(8'hC3, 8);
    tick(6);
    check_eq("ovr_data", 32'(data_out), 32'h3C);
    check_eq("ovr_valid", 32'(valid), 32'd1);
    check_eq("ovr_status", 32'(status), 32'b01);
    cs_high();
    ready = 1'b1;
    tick(2);
    check_eq("ovr_drain_valid", 32'(valid), 32'd0);
    clr_pulse();
    check_eq("ovr_clr", 32'(status), 32'd0);

    // short frame -> frame error
    cs_low();
    send_bits(8'hFF, 5);
    tick(5);
    cs_high();
    check_eq("ferr_valid", 32'(valid), 32'd0);
    check_eq("ferr_status", 32'(status), 32'b10);
    clr_pulse();
    check_eq("ferr_clr", 32'(status), 32'd0);

    // back-to-back with ready pulsed as the second byte completes
    ready = 1'b0; dc_in = 1'b0;
    cs_low();
    exp_q.push_back({1'b0, 8'h01});
    send_bits(8'h01, 8);
    tick(5);
    exp_q.push_back({1'b0, 8'h80});
    send_bits(8'h80, 8);
    tick(3);
    ready = 1'b1;
    check_eq("b2b_pre_valid", 32'(valid), 32'd1);
    tick(1);
    ready = 1'b0;
    check_eq("b2b_valid", 32'(valid), 32'd1);
    check_eq("b2b_data", 32'(data_out), 32'h80);
    check_eq("b2b_status", 32'(status), 32'd0);
    ready = 1'b1;
    tick(2);
    cs_high();

    // disable mid-byte, then a fresh frame
    cs_low();
    send_bits(8'hFF, 4);
    tick(5);
    control = 2'b00;
    tick(3);
    control = 2'b01;
    cs_high();
    dc_in = 1'b1;
    cs_low();
    exp_q.push_back({1'b1, 8'h5A});
    send_bits(8'h5A, 8);
    tick(5);
    cs_high();
    check_eq("dis_status", 32'(status), 32'd0);

    // reset mid-byte with a pending byte
    ready = 1'b0; dc_in = 1'b1;
    cs_low();
    exp_q.push_back({1'b1, 8'h77});
    send_bits(8'h77, 8);
    tick(5);
    check_eq("pre_rst_valid", 32'(valid), 32'd1);
    send_bits(8'hAA, 4);
    tick(2);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(valid), 32'd0);
    check_eq("mid_rst_data", 32'(data_out), 32'h00);
    check_eq("mid_rst_dc", 32'(dc_out), 32'd0);
    check_eq("mid_rst_status", 32'(status), 32'd0);
    exp_q.delete();
    tick(3);
    reset = 1'b1;
    ready = 1'b1;
    send_bits(8'hFF, 8);
    tick(5);
    cs_high();
    check_eq("post_rst_valid", 32'(valid), 32'd0);
    check_eq("post_rst_status", 32'(status), 32'd0);
    dc_in = 1'b0;
    cs_low();
    exp_q.push_back({1'b0, 8'h12});
    send_bits(8'h12, 8);
    tick(5);
    cs_high();
    check_eq("final_queue", 32'(exp_q.size()), 32'd0);
    check_eq("final_status", 32'(status), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
